// File: rtl/i2s_pkg.sv
// i2s_pkg: shared sizing defaults and channel encoding for the I2S transceiver.
package i2s_pkg;

    localparam int DATA_W     = 24;  // sample width in bits
    localparam int SLOT_W     = 32;  // bclk periods per channel half-frame
    localparam int LEAD_SLOTS = 7;   // zero slots preceding the MSB
    localparam int MCLK_DIV   = 4;   // AMSCK-to-mclk ratio, even and >= 2

    // lrck level meaning: high = left channel, low = right channel
    typedef enum logic {
        CH_RIGHT = 1'b0,
        CH_LEFT  = 1'b1
    } channel_t;

    // width of a counter that must hold every value 0..max_val
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: 2-FF synchroniser for an asynchronous codec pin plus
// rise/fall detection on the synchronised level. Edge outputs stay quiet
// until the pipeline has refilled after reset, so a pin already high at
// release is not mistaken for an edge.
module i2s_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic       meta;
    logic       sync;
    logic       prev;
    logic [1:0] fill;

    // synchroniser chain, previous-level register and post-reset fill count
    // NOTE: non-blocking (<=) on every flop so each stage samples the value its predecessor held before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
            fill <= 2'd0;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
            if (fill != 2'd3) begin
                fill <= fill + 2'd1;
            end
        end
    end

    assign q    = sync;
    assign rise = (fill == 2'd3) &&  sync && !prev;
    assign fall = (fill == 2'd3) && !sync &&  prev;

endmodule

// File: rtl/i2s_transceiver.sv
// i2s_transceiver: full-duplex I2S slave port. The codec drives bclk/lrck;
// sdin is deserialised into 24-bit samples with valid strobes and samples
// fetched from din (on rd_l/rd_r requests) are serialised onto sdout.
// mclk is a free-running divide of AMSCK.
// Build option I2S_LOOPBACK_EN: transmit the last received sample of the
// same channel instead of din.
module i2s_transceiver
    import i2s_pkg::*;
#(
    parameter int DATA_W     = i2s_pkg::DATA_W,
    parameter int SLOT_W     = i2s_pkg::SLOT_W,
    parameter int LEAD_SLOTS = i2s_pkg::LEAD_SLOTS,
    parameter int MCLK_DIV   = i2s_pkg::MCLK_DIV
) (
    input  logic              AMSCK,
    input  logic              rst,
    input  logic              lrck,
    input  logic              bclk,
    input  logic              sdin,
    input  logic [DATA_W-1:0] din,
    output logic              sdout,
    output logic              mclk,
    output logic              rd_l,
    output logic              rd_r,
    output logic [DATA_W-1:0] dout,
    output logic              valid_l,
    output logic              valid_r
);

    // slot arithmetic must reach SLOT_W+1 (the "upcoming" slot after saturation)
    localparam int              SB           = cnt_w(SLOT_W + 1);
    localparam logic [SB-1:0]   SLOT_MAX     = SB'(SLOT_W);
    localparam logic [SB-1:0]   FIRST_DATA   = SB'(LEAD_SLOTS + 1);
    localparam logic [SB-1:0]   LAST_DATA    = SB'(LEAD_SLOTS + DATA_W);
    localparam int              MB           = cnt_w(MCLK_DIV);
    localparam logic [MB-1:0]   MCLK_HALF_M1 = MB'(MCLK_DIV / 2 - 1);

    logic              lrck_s, lrck_rise, lrck_fall, lrck_edge;
    logic              bclk_level_unused, bclk_rise, bclk_fall;
    logic              sdin_meta, sdin_s;

    logic [SB-1:0]     slot, slot_next, slot_up;
    logic              rx_in_data, tx_in_data;
    channel_t          chan;
    logic              active;      // set by the first lrck edge after reset
    logic [DATA_W-1:0] rx_shift;
    logic              rx_done;

    logic              tx_load;
    logic [DATA_W-1:0] tx_src;
    logic [DATA_W-1:0] tx_shift;
    logic [MB-1:0]     mclk_cnt;

    i2s_sync_edge u_sync_lrck (
        .clk  (AMSCK),
        .rst  (rst),
        .d    (lrck),
        .q    (lrck_s),
        .rise (lrck_rise),
        .fall (lrck_fall)
    );

    i2s_sync_edge u_sync_bclk (
        .clk  (AMSCK),
        .rst  (rst),
        .d    (bclk),
        .q    (bclk_level_unused),
        .rise (bclk_rise),
        .fall (bclk_fall)
    );

    assign lrck_edge = lrck_rise | lrck_fall;

    // sdin synchroniser, same two-stage depth as i2s_sync_edge
    always_ff @(posedge AMSCK or posedge rst) begin
        if (rst) begin
            sdin_meta <= 1'b0;
            sdin_s    <= 1'b0;
        end else begin
            sdin_meta <= sdin;
            sdin_s    <= sdin_meta;
        end
    end

    // slot numbers seen by the receive path (on rise) and transmit path (on fall)
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        slot_next  = slot + SB'(1);
        slot_up    = (lrck_edge ? '0 : slot) + SB'(1);
        rx_in_data = (slot_next >= FIRST_DATA) && (slot_next <= LAST_DATA);
        tx_in_data = (slot_up >= FIRST_DATA) && (slot_up <= LAST_DATA);
    end

    // slot counter, channel tracking and receive shift register
    always_ff @(posedge AMSCK or posedge rst) begin
        if (rst) begin
            slot     <= '0;
            chan     <= CH_RIGHT;
            active   <= 1'b0;
            rx_shift <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (lrck_edge) begin
                // a new half-frame discards any partial word
                slot     <= '0;
                chan     <= channel_t'(lrck_s);
                active   <= 1'b1;
                rx_shift <= '0;
            end else if (bclk_rise && active) begin
                if (slot != SLOT_MAX) begin
                    slot <= slot_next;
                end
                if (rx_in_data) begin
                    rx_shift <= {rx_shift[DATA_W-2:0], sdin_s};
                end
                if (slot_next == LAST_DATA) begin
                    rx_done <= 1'b1;
                end
            end
        end
    end

    // publish a completed word with a one-cycle channel strobe
    always_ff @(posedge AMSCK or posedge rst) begin
        if (rst) begin
            dout    <= '0;
            valid_l <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            valid_l <= 1'b0;
            valid_r <= 1'b0;
            if (rx_done) begin
                dout    <= rx_shift;
                valid_l <= (chan == CH_LEFT);
                valid_r <= (chan == CH_RIGHT);
            end
        end
    end

    // request the next transmit sample at the start of each half-frame
    always_ff @(posedge AMSCK or posedge rst) begin
        if (rst) begin
            rd_l <= 1'b0;
            rd_r <= 1'b0;
        end else begin
            rd_l <= lrck_edge && (channel_t'(lrck_s) == CH_LEFT);
            rd_r <= lrck_edge && (channel_t'(lrck_s) == CH_RIGHT);
        end
    end

`ifdef I2S_LOOPBACK_EN
    logic [DATA_W-1:0] last_l, last_r;
    logic              din_unused;

    assign din_unused = ^din;

    // remember the newest received sample of each channel
    always_ff @(posedge AMSCK or posedge rst) begin
        if (rst) begin
            last_l <= '0;
            last_r <= '0;
        end else if (rx_done) begin
            if (chan == CH_LEFT) begin
                last_l <= rx_shift;
            end else begin
                last_r <= rx_shift;
            end
        end
    end

    // loopback: load the stored sample of the requested channel on the rd pulse
    always_comb begin
        tx_load = 1'b0;
        tx_src  = '0;
        if (rd_l || rd_r) begin
            tx_load = 1'b1;
            tx_src  = rd_l ? last_l : last_r;
        end
    end
`else
    logic [1:0] ld_dly;

    // delay the request so din is sampled two cycles after the rd pulse
    always_ff @(posedge AMSCK or posedge rst) begin
        if (rst) begin
            ld_dly <= 2'b00;
        end else begin
            ld_dly <= {ld_dly[0], rd_l | rd_r};
        end
    end

    // normal build: transmit data comes from din
    always_comb begin
        tx_load = ld_dly[1];
        tx_src  = din;
    end
`endif

    // transmit shifter: load on request, emit the upcoming slot's bit on each bclk fall
    always_ff @(posedge AMSCK or posedge rst) begin
        if (rst) begin
            tx_shift <= '0;
            sdout    <= 1'b0;
        end else begin
            if (tx_load) begin
                tx_shift <= tx_src;
            end else if (bclk_fall && active && tx_in_data) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
            if (bclk_fall) begin
                sdout <= (active && tx_in_data) ? tx_shift[DATA_W-1] : 1'b0;
            end
        end
    end

    // free-running mclk divider, toggles every MCLK_DIV/2 AMSCK cycles
    always_ff @(posedge AMSCK or posedge rst) begin
        if (rst) begin
            mclk_cnt <= '0;
            mclk     <= 1'b0;
        end else if (mclk_cnt == MCLK_HALF_M1) begin
            mclk_cnt <= '0;
            mclk     <= ~mclk;
        end else begin
            mclk_cnt <= mclk_cnt + MB'(1);
        end
    end

endmodule

// File: tb/tb_i2s_transceiver.sv
// tb_i2s_transceiver: drives codec-side bclk/lrck/sdin half-frames and checks
// received words, strobes, rd requests and the sdout slot pattern against a
// word-level model of the I2S slot layout (7 zero slots, 24 data bits MSB
// first, one trailing zero slot). Pins change 3 ns after a falling AMSCK
// edge; the event recorder samples on falling AMSCK edges.
module tb_i2s_transceiver;

    localparam int DW = 24;

    logic          AMSCK = 1'b0;
    logic          rst;
    logic          lrck;
    logic          bclk;
    logic          sdin;
    logic [DW-1:0] din;
    logic          sdout;
    logic          mclk;
    logic          rd_l;
    logic          rd_r;
    logic [DW-1:0] dout;
    logic          valid_l;
    logic          valid_r;

    int n_cmp  = 0;
    int n_fail = 0;

    // cumulative event totals kept by the recorder
    int            tot_vl  = 0;
    int            tot_vr  = 0;
    int            tot_rdl = 0;
    int            tot_rdr = 0;
    logic [DW-1:0] got_l   = '0;
    logic [DW-1:0] got_r   = '0;

    i2s_transceiver dut (
        .AMSCK   (AMSCK),
        .rst     (rst),
        .lrck    (lrck),
        .bclk    (bclk),
        .sdin    (sdin),
        .din     (din),
        .sdout   (sdout),
        .mclk    (mclk),
        .rd_l    (rd_l),
        .rd_r    (rd_r),
        .dout    (dout),
        .valid_l (valid_l),
        .valid_r (valid_r)
    );

    always #5 AMSCK = ~AMSCK;

    // event recorder: count strobes and keep the word shown with each valid
    always @(negedge AMSCK) begin
        if (valid_l === 1'b1) begin
            tot_vl <= tot_vl + 1;
            got_l  <= dout;
        end
        if (valid_r === 1'b1) begin
            tot_vr <= tot_vr + 1;
            got_r  <= dout;
        end
        if (rd_l === 1'b1) tot_rdl <= tot_rdl + 1;
        if (rd_r === 1'b1) tot_rdr <= tot_rdr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // model: bit carried by slot n of a half-frame holding word w
    function automatic logic slot_bit(input logic [DW-1:0] w, input int n);
        if (n >= 8 && n <= 31) return w[31 - n];
        return 1'b0;
    endfunction

    // one codec half-frame of nb bclk periods; optional reset after fall rst_at
    task automatic half_frame(input logic lr, input logic [DW-1:0] rx_w,
                              input logic [DW-1:0] tx_w, input int nb,
                              input int rst_at, input string tag);
        int          vl0, vr0, rdl0, rdr0;
        logic [31:0] tx_got, tx_exp;
        bit          full;
        vl0    = tot_vl;
        vr0    = tot_vr;
        rdl0   = tot_rdl;
        rdr0   = tot_rdr;
        tx_got = '0;
        tx_exp = '0;
        lrck   = lr;
        din    = tx_w;
        sdin   = slot_bit(rx_w, 1);
        for (int k = 1; k <= nb; k++) begin
            #80;
            tx_got[k-1] = sdout;
            tx_exp[k-1] = (rst_at != 0 && k > rst_at) ? 1'b0 : slot_bit(tx_w, k);
            bclk = 1'b1;
            #80;
            bclk = 1'b0;
            sdin = slot_bit(rx_w, k + 1);
            if (k == rst_at) begin
                #1 rst = 1'b1;
                #1;
                check({tag, "/rst_dout"}, 32'(dout), 32'h0);
                check({tag, "/rst_outs"}, 32'({valid_l, valid_r, rd_l, rd_r, sdout, mclk}), 32'h0);
                #48 rst = 1'b0;
                vl0  = tot_vl;
                vr0  = tot_vr;
                rdl0 = tot_rdl;
                rdr0 = tot_rdr;
            end
        end
        full = (nb >= 31) && (rst_at == 0);
        check({tag, "/valid_l_count"}, 32'(tot_vl - vl0), (full && lr) ? 32'd1 : 32'd0);
        check({tag, "/valid_r_count"}, 32'(tot_vr - vr0), (full && !lr) ? 32'd1 : 32'd0);
        check({tag, "/rd_l_count"}, 32'(tot_rdl - rdl0), (rst_at == 0 && lr) ? 32'd1 : 32'd0);
        check({tag, "/rd_r_count"}, 32'(tot_rdr - rdr0), (rst_at == 0 && !lr) ? 32'd1 : 32'd0);
        if (full) begin
            check({tag, "/dout"}, 32'(lr ? got_l : got_r), 32'(rx_w));
        end
        check({tag, "/sdout_slots"}, tx_got, tx_exp);
    endtask

    initial begin
        logic [DW-1:0] w_rx, w_tx;
        logic          mclk_s [0:40];
        int            bad;

        rst  = 1'b1;
        lrck = 1'b0;
        bclk = 1'b0;
        sdin = 1'b0;
        din  = '0;

        // reset state
        #23;
        check("reset_dout", 32'(dout), 32'h0);
        check("reset_strobes", 32'({valid_l, valid_r, rd_l, rd_r}), 32'h0);
        check("reset_sdout", 32'(sdout), 32'h0);
        check("reset_mclk", 32'(mclk), 32'h0);
        rst = 1'b0;
        #10;
        check("mclk_starts_low", 32'(mclk), 32'h0);

        // bclk running but no lrck edge yet: silent port
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            #80;
            if (sdout !== 1'b0) bad++;
            bclk = 1'b1;
            #80;
            bclk = 1'b0;
            sdin = 1'($urandom);
        end
        check("idle_sdout_ones", 32'(bad), 32'h0);
        check("idle_pulses", 32'(tot_vl + tot_vr + tot_rdl + tot_rdr), 32'h0);

        // mclk: 40 ns period, 50% duty -> level flips every 2 AMSCK cycles
        for (int i = 0; i < 41; i++) begin
            @(negedge AMSCK);
            mclk_s[i] = mclk;
        end
        bad = 0;
        for (int i = 2; i < 41; i++) begin
            if (mclk_s[i] === mclk_s[i-2]) bad++;
        end
        check("mclk_half_period", 32'(bad), 32'h0);
        #3;

        // directed frames
        half_frame(1'b1, 24'h885511, 24'hFF55FF, 32, 0, "left_885511");
        half_frame(1'b0, 24'h123456, 24'hABCDEF, 32, 0, "right_123456");
        half_frame(1'b1, 24'h654321, DW'($urandom), 32, 0, "left_654321");
        half_frame(1'b0, 24'h40724F, DW'($urandom), 32, 0, "right_40724F");

        // randomised alternating frames
        for (int i = 0; i < 6; i++) begin
            w_rx = DW'($urandom);
            w_tx = DW'($urandom);
            half_frame(1'((i % 2) == 0), w_rx, w_tx, 32, 0, $sformatf("rand%0d", i));
        end

        // short frame discarded, next full frame still captured
        half_frame(1'b1, DW'($urandom), DW'($urandom), 20, 0, "short20");
        half_frame(1'b0, DW'($urandom), DW'($urandom), 32, 0, "after_short");

        // reset in the middle of a left half-frame, then recovery
        half_frame(1'b1, DW'($urandom), DW'($urandom), 32, 12, "mid_reset");
        half_frame(1'b0, DW'($urandom), DW'($urandom), 32, 0, "post_reset_r");
        half_frame(1'b1, DW'($urandom), DW'($urandom), 32, 0, "post_reset_l");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
